seg7_scan_decoder: RTL and testbench

//  Readback monitor for the multiplexed 7-segment display: samples the active-low segment and anode

---
 rtl/seg7_scan_decoder_if.sv | 27 ++
 rtl/seg7_scan_decoder.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Display pin readback bundle: sampled segment/anode lines in,
// decoded digits and error status out.
interface seg7_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
) ();
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   an_n;
   logic                    clear;
   logic [4*NUM_DIGITS-1:0] hex_word;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    frame_valid;
   logic                    bad_pattern;
   logic [2:0]              bad_digit;
   logic                    error_sticky;

   modport master (
      output seg_n, an_n, clear,
      input  hex_word, digit_valid, frame_valid,
      input  bad_pattern, bad_digit, error_sticky
   );

   modport slave (
      input  seg_n, an_n, clear,
      output hex_word, digit_valid, frame_valid,
      output bad_pattern, bad_digit, error_sticky
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment readback: debounces each scanned digit,
// decodes it to hex and assembles a coherent display word.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input logic                clk,
   input logic                reset,
   seg7_scan_decoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 2);
   localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

   state_t                  state, state_nx;
   logic [7:0]              cnt, cnt_nx;
   logic [6:0]              s_seg, d_seg;
   logic [NUM_DIGITS-1:0]   s_an, d_an;
   logic [NUM_DIGITS-1:0]   an_low, dv_set;
   logic [4*NUM_DIGITS-1:0] hex_q;
   logic [NUM_DIGITS-1:0]   dv_q;
   logic                    fv_q, bp_q, err_q;
   logic [2:0]              bd_q;
   logic                    scan_ok, same, capture;
   logic                    hit, blank;
   logic [2:0]              idx;
   logic [3:0]              val;

   assign an_low  = ~s_an;
   assign scan_ok = (an_low != '0) &&
                    ((an_low & (an_low - ONE)) == '0);
   assign same    = (s_seg == d_seg) && (s_an == d_an);
   assign blank   = (s_seg == 7'h7f);
   assign dv_set  = dv_q | (ONE << idx);

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (an_low[i]) idx = 3'(i);
   end

   always_comb begin
      hit = 1'b1;
      val = 4'h0;
      case (s_seg)
         7'b0000001: val = 4'h0;
         7'b1001111: val = 4'h1;
         7'b0010010: val = 4'h2;
         7'b0000110: val = 4'h3;
         7'b1001100: val = 4'h4;
         7'b0100100: val = 4'h5;
         7'b0100000: val = 4'h6;
         7'b0001111: val = 4'h7;
         7'b0000000: val = 4'h8;
         7'b0001100: val = 4'h9;
         7'b0001000: val = 4'ha;
         7'b1100000: val = 4'hb;
         7'b0110001: val = 4'hc;
         7'b1000010: val = 4'hd;
         7'b0110000: val = 4'he;
         7'b0111000: val = 4'hf;
         default:    hit = 1'b0;
      endcase
   end

   // cnt lags the sample run by one, so capture lands on the
   // edge after STABLE_CYCLES identical samples
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      capture  = 1'b0;
      if (bus.clear) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_nx = '0;
               if (scan_ok) state_nx = SETTLE;
            end
            SETTLE: begin
               if (!scan_ok) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (!same) begin
                  cnt_nx = '0;
               end else if (cnt == CAP_CNT) begin
                  capture  = 1'b1;
                  state_nx = HELD;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 8'd1;
               end
            end
            HELD: begin
               if (!scan_ok) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (!same) begin
                  state_nx = SETTLE;
                  cnt_nx   = '0;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         s_seg <= '1;
         d_seg <= '1;
         s_an  <= '1;
         d_an  <= '1;
         hex_q <= '0;
         dv_q  <= '0;
         fv_q  <= 1'b0;
         bp_q  <= 1'b0;
         bd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         s_seg <= bus.seg_n;
         s_an  <= bus.an_n;
         d_seg <= s_seg;
         d_an  <= s_an;
         fv_q  <= 1'b0;
         bp_q  <= 1'b0;
         if (bus.clear) begin
            dv_q  <= '0;
            err_q <= 1'b0;
         end else if (capture && hit) begin
            for (int i = 0; i < NUM_DIGITS; i++)
               if (idx == 3'(i)) hex_q[4*i +: 4] <= val;
            if (dv_set == '1) begin
               fv_q <= 1'b1;
               dv_q <= '0;
            end else begin
               dv_q <= dv_set;
            end
         end else if (capture && !blank) begin
            bp_q  <= 1'b1;
            bd_q  <= idx;
            err_q <= 1'b1;
         end
      end
   end

   assign bus.hex_word     = hex_q;
   assign bus.digit_valid  = dv_q;
   assign bus.frame_valid  = fv_q;
   assign bus.bad_pattern  = bp_q;
   assign bus.bad_digit    = bd_q;
   assign bus.error_sticky = err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized and directed bench for seg7_scan_decoder against a
// run-length reference model of the debounce/decode rules.
module tb_seg7_scan_decoder;
   localparam int ND = 4;
   localparam int SC = 8;

   logic clk = 1'b0;
   logic reset;

   seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_decoder #(
      .NUM_DIGITS(ND),
      .STABLE_CYCLES(SC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   logic [6:0] codes [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int n_vec = 0;
   int n_bad = 0;
   int cnt_fv = 0;
   int cnt_bp = 0;
   int cnt_rise = 0;
   logic last_dv2 = 1'b0;

   logic [15:0] m_hex;
   logic [3:0]  m_dv;
   logic        m_fv, m_bp, m_err;
   logic [2:0]  m_bd;
   int          run;
   logic [6:0]  p_seg;
   logic [3:0]  p_an;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int one_idx(logic [3:0] an);
      int k = -1;
      int c = 0;
      for (int i = 0; i < ND; i++)
         if (!an[i]) begin
            c++;
            k = i;
         end
      return (c == 1) ? k : -1;
   endfunction

   function automatic int lookup(logic [6:0] s);
      for (int i = 0; i < 16; i++)
         if (codes[i] == s) return i;
      return -1;
   endfunction

   // run = length of the current streak of identical valid samples
   task automatic model_edge();
      int id;
      int v;
      logic [3:0] nd;
      if (reset) begin
         m_hex = '0;
         m_dv  = '0;
         m_fv  = 1'b0;
         m_bp  = 1'b0;
         m_bd  = '0;
         m_err = 1'b0;
         run   = 0;
         p_seg = '1;
         p_an  = '1;
      end else begin
         m_fv = 1'b0;
         m_bp = 1'b0;
         if (run == SC && !bus.clear) begin
            id = one_idx(p_an);
            v  = lookup(p_seg);
            if (v >= 0) begin
               m_hex[id*4 +: 4] = 4'(v);
               nd = m_dv | (4'b0001 << id);
               if (nd == 4'hf) begin
                  m_fv = 1'b1;
                  m_dv = '0;
               end else begin
                  m_dv = nd;
               end
            end else if (p_seg != 7'h7f) begin
               m_bp  = 1'b1;
               m_bd  = 3'(id);
               m_err = 1'b1;
            end
         end
         if (bus.clear) begin
            m_dv  = '0;
            m_err = 1'b0;
         end
         id = one_idx(bus.an_n);
         if (!bus.clear && id >= 0 &&
             bus.seg_n == p_seg && bus.an_n == p_an)
            run = (run < 1000) ? run + 1 : run;
         else
            run = (id >= 0) ? 1 : 0;
         p_seg = bus.seg_n;
         p_an  = bus.an_n;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("hex", bus.hex_word, m_hex);
      chk("dv", bus.digit_valid, m_dv);
      chk("fv", bus.frame_valid, m_fv);
      chk("bp", bus.bad_pattern, m_bp);
      chk("bd", bus.bad_digit, m_bd);
      chk("err", bus.error_sticky, m_err);
      if (bus.frame_valid) cnt_fv++;
      if (bus.bad_pattern) cnt_bp++;
      if (bus.digit_valid[2] && !last_dv2) cnt_rise++;
      last_dv2 = bus.digit_valid[2];
   endtask

   task automatic hold(logic [3:0] an, logic [6:0] seg, int n);
      bus.an_n  = an;
      bus.seg_n = seg;
      repeat (n) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset     = 1'b1;
      bus.clear = 1'b0;
      bus.an_n  = 4'b1110;
      bus.seg_n = 7'b0000001;
      repeat (2) begin
         step();
         chk("rst_hex", bus.hex_word, 0);
         chk("rst_dv", bus.digit_valid, 0);
         chk("rst_err", bus.error_sticky, 0);
      end
      reset = 1'b0;
      repeat (8) step();
      chk("t1_early", bus.digit_valid, 0);
      step();
      chk("t1_dv", bus.digit_valid, 4'b0001);
      chk("t1_nib", bus.hex_word[3:0], 0);

      cnt_fv = 0;
      hold(4'b1110, codes[1], 12);
      hold(4'b1101, codes[2], 12);
      hold(4'b1011, codes[3], 12);
      hold(4'b0111, codes[15], 12);
      chk("t2_frames", cnt_fv, 1);
      chk("t2_hex", bus.hex_word, 16'hf321);
      chk("t2_dv", bus.digit_valid, 0);

      cnt_bp = 0;
      hold(4'b1101, 7'b1111110, 12);
      chk("t3_bp", cnt_bp, 1);
      chk("t3_bd", bus.bad_digit, 1);
      chk("t3_err", bus.error_sticky, 1);
      chk("t3_hex", bus.hex_word, 16'hf321);
      cnt_bp = 0;
      hold(4'b1101, 7'h7f, 12);
      chk("t3_blank", cnt_bp, 0);

      for (int k = 0; k < 8; k++)
         hold(4'b1110, k[0] ? codes[8] : codes[0], 5);
      chk("t4_glitch_dv", bus.digit_valid, 0);
      chk("t4_glitch_hex", bus.hex_word, 16'hf321);
      hold(4'b1100, codes[5], 12);
      hold(4'b1111, codes[5], 12);
      chk("t4_inv_dv", bus.digit_valid, 0);

      hold(4'b1110, codes[4], 12);
      hold(4'b1101, codes[5], 12);
      hold(4'b1011, codes[6], 12);
      chk("t5_pre_dv", bus.digit_valid, 4'b0111);
      cnt_fv    = 0;
      bus.an_n  = 4'b0111;
      bus.seg_n = codes[7];
      repeat (8) step();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      chk("t5_dv", bus.digit_valid, 0);
      chk("t5_fv", cnt_fv, 0);
      chk("t5_err", bus.error_sticky, 0);
      chk("t5_hex", bus.hex_word, 16'hf654);
      repeat (12) step();

      for (int v = 0; v < 16; v++) begin
         hold(4'b1011, codes[v], 12);
         chk("t6_nib", bus.hex_word[11:8], v);
      end
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      cnt_rise  = 0;
      hold(4'b1011, codes[9], 40);
      chk("t6_single", cnt_rise, 1);

      repeat (250) begin
         if ($urandom_range(0, 99) < 85)
            bus.an_n = ~(4'b0001 << $urandom_range(0, 3));
         else
            bus.an_n = 4'($urandom);
         n = $urandom_range(0, 99);
         if (n < 70)
            bus.seg_n = codes[$urandom_range(0, 15)];
         else if (n < 80)
            bus.seg_n = 7'h7f;
         else
            bus.seg_n = 7'($urandom);
         bus.clear = ($urandom_range(0, 19) == 0);
         reset     = ($urandom_range(0, 39) == 0);
         step();
         bus.clear = 1'b0;
         reset     = 1'b0;
         repeat ($urandom_range(0, 13)) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end
endmodule
